assoc_cache: RTL

//  2-way set-associative, write-back, write-allocate data cache; one word per line.

---
 rtl/assoc_cache_if.sv | 32 +++
 rtl/assoc_cache.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/assoc_cache_if.sv
// assoc_cache_if: CPU load/store bus and main-memory bus of the data cache.
//   CPU side : req, we, addr, wdata (to cache); rdata, hit, stall (from cache)
//   Mem side : mem_req, mem_we, mem_addr, mem_wdata (from cache); mem_ready, mem_rdata (to cache)
//   slave  modport : the cache
//   master modport : the environment (CPU pipeline plus memory controller)
interface assoc_cache_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req;
   logic                  we;
   logic [DATA_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  hit;
   logic                  stall;
   logic                  mem_req;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_ready;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  req, we, addr, wdata, mem_ready, mem_rdata,
      output rdata, hit, stall, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, we, addr, wdata, mem_ready, mem_rdata,
      input  rdata, hit, stall, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/assoc_cache.sv
// assoc_cache: 2-way set-associative, write-back, write-allocate data cache,
// one word per line, 1-bit LRU per set, saturating hit/miss counters.
// Hits are answered combinationally; a miss stalls the CPU while the FSM
// writes back a dirty victim (if any) and then refills the line.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : assoc_cache_if.slave (CPU request/response + memory request/response)
//   hit_count  : saturating count of hit accesses
//   miss_count : saturating count of misses (one per miss)
module assoc_cache #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SET_WIDTH  = 6,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   assoc_cache_if.slave         bus,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);
   localparam int unsigned TAG_WIDTH  = DATA_WIDTH - SET_WIDTH - 2;
   localparam int unsigned LINE_WIDTH = DATA_WIDTH - 2;
   localparam int unsigned NUM_SETS   = 1 << SET_WIDTH;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

   state_t state, state_nxt;

   logic [1:0][NUM_SETS-1:0] valid;
   logic [1:0][NUM_SETS-1:0] dirty;
   logic [NUM_SETS-1:0]      lru;
   logic [TAG_WIDTH-1:0]     tag_mem  [2][NUM_SETS];
   logic [DATA_WIDTH-1:0]    data_mem [2][NUM_SETS];

   logic [SET_WIDTH-1:0]  cur_set, miss_set;
   logic [TAG_WIDTH-1:0]  cur_tag, miss_tag;
   logic [LINE_WIDTH-1:0] miss_line;
   logic [1:0]            way_hit;
   logic                  hit_way;
   logic                  victim_way, victim_nxt;
   logic                  miss_start, refill_done;
   logic                  unused_addr_bits;

   assign cur_set   = bus.addr[SET_WIDTH+1:2];
   assign cur_tag   = bus.addr[DATA_WIDTH-1:SET_WIDTH+2];
   assign miss_set  = miss_line[SET_WIDTH-1:0];
   assign miss_tag  = miss_line[LINE_WIDTH-1:SET_WIDTH];
   assign unused_addr_bits = ^bus.addr[1:0];

   // Tag compare on both ways of the addressed set
   assign way_hit[0] = valid[0][cur_set] && (tag_mem[0][cur_set] == cur_tag);
   assign way_hit[1] = valid[1][cur_set] && (tag_mem[1][cur_set] == cur_tag);
   assign hit_way    = way_hit[1];

   // Victim: first invalid way, otherwise the LRU way of the set
   assign victim_nxt = !valid[0][cur_set] ? 1'b0 :
                       !valid[1][cur_set] ? 1'b1 : lru[cur_set];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and bus outputs
   always_comb begin
      state_nxt     = state;
      bus.hit       = 1'b0;
      bus.stall     = 1'b0;
      bus.rdata     = data_mem[hit_way][cur_set];
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      miss_start    = 1'b0;
      refill_done   = 1'b0;
      unique case (state)
         IDLE: begin
            bus.hit = bus.req && (|way_hit);
            if (bus.req && !(|way_hit)) begin
               bus.stall  = 1'b1;
               miss_start = 1'b1;
               state_nxt  = (valid[victim_nxt][cur_set] && dirty[victim_nxt][cur_set])
                            ? WRITEBACK : REFILL;
            end
         end
         WRITEBACK: begin
            bus.stall     = 1'b1;
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {tag_mem[victim_way][miss_set], miss_set, 2'b00};
            bus.mem_wdata = data_mem[victim_way][miss_set];
            if (bus.mem_ready) state_nxt = REFILL;
         end
         REFILL: begin
            bus.stall    = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = {miss_line, 2'b00};
            if (bus.mem_ready) begin
               refill_done = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Line status, LRU, miss context and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid      <= '0;
         dirty      <= '0;
         lru        <= '0;
         miss_line  <= '0;
         victim_way <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (miss_start) begin
            miss_line  <= bus.addr[DATA_WIDTH-1:2];
            victim_way <= victim_nxt;
            if (!(&miss_count)) miss_count <= miss_count + CNT_WIDTH'(1);
         end
         if (bus.hit) begin
            lru[cur_set] <= ~hit_way;
            if (bus.we) dirty[hit_way][cur_set] <= 1'b1;
            if (!(&hit_count)) hit_count <= hit_count + CNT_WIDTH'(1);
         end
         if (refill_done) begin
            valid[victim_way][miss_set] <= 1'b1;
            dirty[victim_way][miss_set] <= 1'b0;
         end
      end
   end

   // Tag and data arrays (no reset)
   always_ff @(posedge clk) begin
      if (bus.hit && bus.we) data_mem[hit_way][cur_set] <= bus.wdata;
      if (refill_done) begin
         data_mem[victim_way][miss_set] <= bus.mem_rdata;
         tag_mem[victim_way][miss_set]  <= miss_tag;
      end
   end
endmodule
